// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified-RAM port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t     : which requester owns the access in flight
//   N_DEFAULT, LAT_DEFAULT, MAXSKIP_DEFAULT : default widths/latency/fairness
//   LAT_W, SKIP_W : widths of the latency and skip counters
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

    localparam int N_DEFAULT       = 24;
    localparam int LAT_DEFAULT     = 2;
    localparam int MAXSKIP_DEFAULT = 4;
    localparam int LAT_W           = 3;
    localparam int SKIP_W          = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the fetch, memory-stage and RAM signals.
//   slave  : arbiter view (requests and RAM read data in; RAM strobes,
//            done pulses, read words and stalls out)
//   master : requester/RAM view (the mirror of slave)
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    logic         ifReq;
    logic [N-1:0] ifAddr;
    logic         flushIF;
    logic         memReq;
    logic         memWe;
    logic [N-1:0] memAddr;
    logic [N-1:0] memWdata;
    logic [N-1:0] ramRdata;
    logic         ramEn;
    logic         ramWe;
    logic [N-1:0] ramAddr;
    logic [N-1:0] ramWdata;
    logic         ifDone;
    logic [N-1:0] ifRdata;
    logic         memDone;
    logic [N-1:0] memRdata;
    logic         stallIF;
    logic         stallMem;

    modport slave (
        input  ifReq, ifAddr, flushIF, memReq, memWe, memAddr, memWdata, ramRdata,
        output ramEn, ramWe, ramAddr, ramWdata, ifDone, ifRdata, memDone, memRdata,
               stallIF, stallMem
    );

    modport master (
        output ifReq, ifAddr, flushIF, memReq, memWe, memAddr, memWdata, ramRdata,
        input  ramEn, ramWe, ramAddr, ramWdata, ifDone, ifRdata, memDone, memRdata,
               stallIF, stallMem
    );
endinterface

// File: rtl/lat_counter.sv
// lat_counter: loadable down-counter timing the RAM read latency.
//   clk, rst   : clock, asynchronous active-high reset
//   i_load     : load i_loadVal (has priority over decrement)
//   i_loadVal  : value to load
//   i_dec      : decrement by one, holding at zero
//   o_last     : high while the count equals 1 (final wait cycle)
module lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    input  logic         i_dec,
    output logic         o_last
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_last = (r_count == W'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the single-port unified RAM between the fetch
// stage (reads) and the memory stage (reads/writes). One access at a time:
// IDLE picks a winner, ISSUE strobes the RAM for one cycle, WAIT sits out the
// read latency, RESP pulses the owner's done. The memory stage has priority,
// but after MAXSKIP consecutive memory wins with fetch waiting, fetch wins.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (requests, RAM port, done/rdata,
//              stall levels for the pipeline buffers)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int LAT     = LAT_DEFAULT,
    parameter int MAXSKIP = MAXSKIP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus
);
    arb_state_t        r_state;
    arb_state_t        w_nextState;
    owner_t            r_owner;
    logic [N-1:0]      r_addr;
    logic [N-1:0]      r_wdata;
    logic              r_we;
    logic [SKIP_W-1:0] r_skipCnt;
    logic              r_cancel;
    logic [N-1:0]      r_ifRdata;
    logic [N-1:0]      r_memRdata;

    logic w_ifElig;
    logic w_skipFull;
    logic w_grantIf;
    logic w_grantMem;
    logic w_latLast;
    logic w_capture;
    logic w_ifCancel;

    // A fetch flushed in the same cycle it would be granted is not eligible.
    assign w_ifElig   = bus.ifReq & ~bus.flushIF;
    assign w_skipFull = (r_skipCnt == SKIP_W'(MAXSKIP));
    assign w_grantIf  = (r_state == IDLE) & w_ifElig & (~bus.memReq | w_skipFull);
    assign w_grantMem = (r_state == IDLE) & bus.memReq & ~w_grantIf;
    assign w_capture  = (r_state == WAIT) & w_latLast;
    // A flush arriving in the capture or response cycle itself also cancels.
    assign w_ifCancel = (r_owner == OWN_IF) & (r_cancel | bus.flushIF);

    lat_counter #(
        .W(LAT_W)
    ) u_latCnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    ((r_state == ISSUE) & ~r_we),
        .i_loadVal (LAT_W'(LAT)),
        .i_dec     (r_state == WAIT),
        .o_last    (w_latLast)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_grantIf || w_grantMem) w_nextState = ISSUE;
            ISSUE:   w_nextState = r_we ? RESP : WAIT;
            WAIT:    if (w_latLast) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ramEn    = 1'b0;
        bus.ramWe    = 1'b0;
        bus.ramAddr  = '0;
        bus.ramWdata = '0;
        bus.ifDone   = 1'b0;
        bus.memDone  = 1'b0;
        case (r_state)
            ISSUE: begin
                bus.ramEn    = 1'b1;
                bus.ramWe    = r_we;
                bus.ramAddr  = r_addr;
                bus.ramWdata = r_wdata;
            end
            RESP: begin
                if (r_owner == OWN_IF) begin
                    bus.ifDone = ~w_ifCancel;
                end else begin
                    bus.memDone = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.stallIF  = bus.ifReq & ~bus.ifDone;
    assign bus.stallMem = bus.memReq & ~bus.memDone;
    assign bus.ifRdata  = r_ifRdata;
    assign bus.memRdata = r_memRdata;

    // Access latch: captured once at grant, held for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_grantIf) begin
            r_owner <= OWN_IF;
            r_addr  <= bus.ifAddr;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_grantMem) begin
            r_owner <= OWN_MEM;
            r_addr  <= bus.memAddr;
            r_we    <= bus.memWe;
            r_wdata <= bus.memWdata;
        end
    end

    // Fetch-cancel flag: cleared on each grant, set by a flush while a fetch
    // access is in flight. The RAM access itself always runs to completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cancel <= 1'b0;
        end else if (w_grantIf || w_grantMem) begin
            r_cancel <= 1'b0;
        end else if ((r_state != IDLE) && (r_owner == OWN_IF) && bus.flushIF) begin
            r_cancel <= 1'b1;
        end
    end

    // Skip counter: consecutive memory-stage wins while fetch was requesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skipCnt <= '0;
        end else if (w_grantIf) begin
            r_skipCnt <= '0;
        end else if (w_grantMem && bus.ifReq && !w_skipFull) begin
            r_skipCnt <= r_skipCnt + SKIP_W'(1);
        end
    end

    // Read-data registers hold their value between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifRdata  <= '0;
            r_memRdata <= '0;
        end else if (w_capture) begin
            if (r_owner == OWN_MEM) begin
                r_memRdata <= bus.ramRdata;
            end else if (!w_ifCancel) begin
                r_ifRdata <= bus.ramRdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Requester tasks push the expected done-response when they raise a request;
// a negedge monitor pops and compares on every done pulse and logs RAM
// strobes/done cycles for the directed timing checks. A behavioural RAM with
// LAT-cycle read delay drives ramRdata; a separate reference memory predicts
// read data from request order alone.
module tb_mem_port_arbiter;
    localparam int N       = 24;
    localparam int LAT     = 2;
    localparam int MAXSKIP = 4;

    typedef struct {
        int           cyc;
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mem_port_arbiter_if #(.N(N)) bus ();

    mem_port_arbiter #(
        .N       (N),
        .LAT     (LAT),
        .MAXSKIP (MAXSKIP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM and reference memory
    logic [N-1:0] ram     [logic [N-1:0]];
    logic [N-1:0] ref_mem [logic [N-1:0]];
    logic [N-1:0] rd_pipe [0:LAT];
    logic [N-1:0] if_q[$];
    logic [N-1:0] mem_q[$];
    acc_t         ram_log[$];
    int           if_done_log[$];
    int           mem_done_log[$];
    logic [N-1:0] last_if_rd;
    logic [N-1:0] last_mem_rd;

    function automatic logic [N-1:0] init_word(input logic [N-1:0] a);
        logic [N-1:0] m;
        m = a * 24'h0009E3;
        return (a == 24'h000010) ? 24'hABCDEF : (m ^ 24'h5A5A5A);
    endfunction

    function automatic logic [N-1:0] ram_rd(input logic [N-1:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction

    function automatic logic [N-1:0] ref_rd(input logic [N-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Read data becomes valid LAT cycles after the strobe cycle; otherwise
    // ramRdata carries noise so an early or late capture is visible.
    assign bus.ramRdata = rd_pipe[LAT];
    always @(negedge clk) begin
        if (bus.ramEn && bus.ramWe) ram[bus.ramAddr] = bus.ramWdata;
        for (int i = LAT; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (bus.ramEn && !bus.ramWe) ? ram_rd(bus.ramAddr) : N'($urandom);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ramEn) begin
                acc_t a;
                a.cyc = cyc; a.we = bus.ramWe; a.addr = bus.ramAddr; a.wdata = bus.ramWdata;
                ram_log.push_back(a);
            end
            if (bus.ifDone) begin
                if_done_log.push_back(cyc);
                check("ifDone_expected", (if_q.size() > 0), 1);
                if (if_q.size() > 0) check("ifRdata", bus.ifRdata, if_q.pop_front());
            end
            if (bus.memDone) begin
                mem_done_log.push_back(cyc);
                check("memDone_expected", (mem_q.size() > 0), 1);
                if (mem_q.size() > 0) check("memRdata", bus.memRdata, mem_q.pop_front());
            end
        end
    end

    task automatic clear_logs();
        ram_log.delete();
        if_done_log.delete();
        mem_done_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ifReq = 1'b0; bus.ifAddr = '0; bus.flushIF = 1'b0;
        bus.memReq = 1'b0; bus.memWe = 1'b0; bus.memAddr = '0; bus.memWdata = '0;
        if_q.delete();
        mem_q.delete();
        clear_logs();
        last_if_rd = '0;
        last_mem_rd = '0;
        #1;
        check("reset_ctrl", {bus.ramEn, bus.ramWe, bus.ifDone, bus.memDone,
                             bus.stallIF, bus.stallMem}, '0);
        check("reset_ram_bus", {bus.ramAddr, bus.ramWdata}, '0);
        check("reset_rdata", {bus.ifRdata, bus.memRdata}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Requesters: called #1 after a rising edge, return #1 after a rising edge.
    task automatic req_fetch(input logic [N-1:0] a);
        logic [N-1:0] e;
        int n;
        e = ref_rd(a);
        last_if_rd = e;
        if_q.push_back(e);
        bus.ifAddr = a;
        bus.ifReq = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ifDone && n < 60);
        check("fetch_done_in_time", bus.ifDone, 1);
        @(posedge clk); #1;
        bus.ifReq = 1'b0;
    endtask

    task automatic req_mem(input logic we, input logic [N-1:0] a, input logic [N-1:0] wd);
        logic [N-1:0] e;
        int n;
        if (we) begin
            e = last_mem_rd;
            ref_mem[a] = wd;
        end else begin
            e = ref_rd(a);
            last_mem_rd = e;
        end
        mem_q.push_back(e);
        bus.memWe = we;
        bus.memAddr = a;
        bus.memWdata = wd;
        bus.memReq = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.memDone && n < 60);
        check("mem_done_in_time", bus.memDone, 1);
        @(posedge clk); #1;
        bus.memReq = 1'b0;
        bus.memWe = 1'b0;
    endtask

    task automatic idle_gap(input int unsigned g);
        repeat (g) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        logic seen;
        logic [N-1:0] prev;
        logic [N-1:0] e;

        bus.ifReq = 1'b0; bus.ifAddr = '0; bus.flushIF = 1'b0;
        bus.memReq = 1'b0; bus.memWe = 1'b0; bus.memAddr = '0; bus.memWdata = '0;
        #2;
        do_reset();

        // Fetch read timing and stall window
        t0 = cyc;
        if_q.push_back(ref_rd(24'h000010));
        last_if_rd = ref_rd(24'h000010);
        bus.ifAddr = 24'h000010;
        bus.ifReq = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("fetch_stallIF_c%0d", k), bus.stallIF, (k < 4));
        end
        @(posedge clk); #1;
        bus.ifReq = 1'b0;
        check("fetch_issue_cyc", (ram_log.size() > 0) ? ram_log[0].cyc : -1, t0 + 1);
        check("fetch_issue_addr", (ram_log.size() > 0) ? ram_log[0].addr : '1, 24'h000010);
        check("fetch_done_cyc", (if_done_log.size() > 0) ? if_done_log[0] : -1, t0 + LAT + 2);

        // Memory write: timing, data, memRdata untouched
        req_mem(1'b0, 24'h000100, '0);
        clear_logs();
        t0 = cyc;
        mem_q.push_back(last_mem_rd);
        ref_mem[24'h000100] = 24'h123456;
        bus.memWe = 1'b1; bus.memAddr = 24'h000100; bus.memWdata = 24'h123456;
        bus.memReq = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            check($sformatf("write_stallMem_c%0d", k), bus.stallMem, (k < 2));
        end
        @(posedge clk); #1;
        bus.memReq = 1'b0; bus.memWe = 1'b0;
        check("write_issue_cyc", (ram_log.size() > 0) ? ram_log[0].cyc : -1, t0 + 1);
        check("write_ramWe", (ram_log.size() > 0) ? ram_log[0].we : 1'b0, 1);
        check("write_ramWdata", (ram_log.size() > 0) ? ram_log[0].wdata : '0, 24'h123456);
        check("write_done_cyc", (mem_done_log.size() > 0) ? mem_done_log[0] : -1, t0 + 2);
        req_mem(1'b0, 24'h000100, '0);

        // Simultaneous requests: memory stage first, fetch follows
        do_reset();
        t0 = cyc;
        fork
            req_mem(1'b0, 24'h000140, '0);
            req_fetch(24'h000020);
        join
        check("simul_first_owner", (ram_log.size() > 0) ? ram_log[0].addr : '0, 24'h000140);
        check("simul_mem_done_cyc", (mem_done_log.size() > 0) ? mem_done_log[0] : -1, t0 + 4);
        check("simul_if_issue_cyc", (ram_log.size() > 1) ? ram_log[1].cyc : -1, t0 + 6);
        check("simul_if_done_cyc", (if_done_log.size() > 0) ? if_done_log[0] : -1, t0 + 9);

        // Fairness: MAXSKIP memory accesses, then the waiting fetch
        do_reset();
        fork
            req_fetch(24'h000030);
            begin
                for (int i = 0; i < 6; i++) req_mem(1'b0, 24'h000100 + N'(i), '0);
            end
        join
        for (int i = 0; i < 6; i++) begin
            int act;
            act = (ram_log.size() > i) ? int'(ram_log[i].addr < 24'h000100) : 2;
            check($sformatf("fair_order_%0d", i), act, (i == MAXSKIP));
        end

        // Flush during a fetch WAIT
        do_reset();
        req_fetch(24'h000048);
        clear_logs();
        bus.ifAddr = 24'h000040;
        bus.ifReq = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ramEn && n < 20);
        check("flush_first_issue_addr", bus.ramAddr, 24'h000040);
        @(posedge clk); #1;
        bus.flushIF = 1'b1;
        prev = last_if_rd;
        bus.ifAddr = 24'h000044;
        e = ref_rd(24'h000044);
        if_q.push_back(e);
        last_if_rd = e;
        @(posedge clk); #1;
        bus.flushIF = 1'b0;
        n = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.ramEn && (bus.ramAddr == 24'h000044) && !seen) begin
                seen = 1'b1;
                check("flush_ifRdata_held", bus.ifRdata, prev);
            end
        end while (!bus.ifDone && n < 40);
        check("flush_refetch_done", bus.ifDone, 1);
        @(posedge clk); #1;
        bus.ifReq = 1'b0;
        check("flush_access_count", ram_log.size(), 2);
        check("flush_done_count", if_done_log.size(), 1);

        // Reset while waiting out a read
        do_reset();
        bus.memAddr = 24'h000150;
        bus.memWe = 1'b0;
        bus.memReq = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ramEn && n < 20);
        @(posedge clk); #1;
        do_reset();
        idle_gap(8);
        check("rst_mid_wait_no_done", if_done_log.size() + mem_done_log.size(), 0);
        req_fetch(24'h000060);

        // Randomized concurrent traffic
        do_reset();
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    req_fetch(N'($urandom_range(0, 255)));
                    idle_gap($urandom_range(0, 3));
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    req_mem(1'($urandom_range(0, 1)), 24'h000100 + N'($urandom_range(0, 15)),
                            N'($urandom));
                    idle_gap($urandom_range(0, 3));
                end
            end
        join
        idle_gap(4);
        check("if_queue_drained", if_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
